// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared fetch FSM state encodings for the instruction-fetch front end.
package inst_fetch_queue_pkg;
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_IDLE    = 2'd0;
  localparam fetch_state_t S_WAIT    = 2'd1;
  localparam fetch_state_t S_DISCARD = 2'd2;
  localparam fetch_state_t S_HALT    = 2'd3;
endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of {pc,inst} words with push, pop, sync flush and occupancy count.
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: variable-latency instruction fetch FSM feeding a {pc,inst} queue to decode.
// Defining FETCH_PERF_CNT_EN adds a saturating flush_count output.
module inst_fetch_queue import inst_fetch_queue_pkg::*; #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic                 inst_valid,
  output logic [WORD_SIZE-1:0] inst,
  output logic [WORD_SIZE-1:0] inst_pc,
  input  logic                 inst_ready,
  output logic [WORD_SIZE-1:0] fetch_count,
`ifdef FETCH_PERF_CNT_EN
  output logic [WORD_SIZE-1:0] flush_count,
`endif
  output logic                 is_halted
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  fetch_state_t state, state_n;
  logic [WORD_SIZE-1:0] fetch_pc, disc_addr;
  logic [2*WORD_SIZE-1:0] head;
  logic [AW:0] count, count_n;
  logic halt_q, hlt, redir, issue, push, pop;
  assign hlt = halt || halt_q;
  assign redir = redirect && state != S_HALT;
  // No issue on a redirect cycle so a request never targets the stale stream
  assign issue = state == S_IDLE && !hlt && !redirect && count < FULL;
  assign push = state == S_WAIT && i_ready && !redirect;
  assign pop = inst_valid && inst_ready && !redir;
  assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);
  assign i_readM = !Reset && (issue || state == S_WAIT || state == S_DISCARD);
  assign i_address = state == S_DISCARD ? disc_addr : fetch_pc;
  assign inst_valid = count != '0;
  assign inst_pc = inst_valid ? head[2*WORD_SIZE-1:WORD_SIZE] : '0;
  assign inst = inst_valid ? head[WORD_SIZE-1:0] : '0;
  assign is_halted = state == S_HALT;
  fetch_fifo #(.W(2*WORD_SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk(Clk),
    .rst(Reset),
    .push(push),
    .pop(pop),
    .flush(redir),
    .wdata({fetch_pc, i_data}),
    .rdata(head),
    .count(count)
  );
  always_comb begin
    state_n = state;
    if (state == S_IDLE) state_n = hlt ? S_HALT : issue ? S_WAIT : S_IDLE;
    else if (state == S_WAIT) state_n = redirect ? (i_ready ? S_IDLE : S_DISCARD) :
                                        !i_ready ? S_WAIT : hlt ? S_HALT :
                                        count_n < FULL ? S_WAIT : S_IDLE;
    else if (state == S_DISCARD) state_n = i_ready ? S_IDLE : S_DISCARD;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      disc_addr   <= '0;
      halt_q      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state  <= state_n;
      halt_q <= hlt;
      if (redir) fetch_pc <= redirect_pc;
      else if (push) fetch_pc <= fetch_pc + 1'b1;
      // The abandoned request keeps its address on the bus until memory answers
      if (state == S_WAIT && redirect && !i_ready) disc_addr <= fetch_pc;
      if (pop) fetch_count <= fetch_count + 1'b1;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic dropped;
  logic [WORD_SIZE:0] fc_sum;
  assign dropped = i_ready && (state == S_DISCARD || (state == S_WAIT && redirect));
  assign fc_sum = {1'b0, flush_count} + (redir ? (WORD_SIZE+1)'(count) : '0) + (WORD_SIZE+1)'(dropped);
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) flush_count <= '0;
    else flush_count <= fc_sum[WORD_SIZE] ? '1 : fc_sum[WORD_SIZE-1:0];
  end
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed vector table plus hand sequences for redirect, halt and flush counting.
module tb_inst_fetch_queue;
  logic        Clk, Reset, i_readM, i_ready, redirect, halt, inst_valid, inst_ready, is_halted;
  logic [15:0] i_address, i_data, redirect_pc, inst, inst_pc, fetch_count;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] flush_count;
`endif
  int total = 0;
  int passed = 0;
  inst_fetch_queue dut (
    .Clk(Clk), .Reset(Reset), .i_readM(i_readM), .i_address(i_address), .i_data(i_data),
    .i_ready(i_ready), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .fetch_count(fetch_count),
`ifdef FETCH_PERF_CNT_EN
    .flush_count(flush_count),
`endif
    .is_halted(is_halted)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  assign i_data = 16'h5A00 ^ i_address;
  typedef struct {
    bit rs, rdy, red;
    logic [15:0] rpc;
    bit hlt, ir, rm;
    logic [15:0] a;
    bit vl;
    logic [15:0] pc, fc;
    bit h;
  } vec_t;
  vec_t vq[$];
  function automatic vec_t v(bit rs, bit rdy, bit red, logic [15:0] rpc, bit hlt, bit ir,
                             bit rm, logic [15:0] a, bit vl, logic [15:0] pc, logic [15:0] fc, bit h);
    vec_t r;
    r.rs = rs; r.rdy = rdy; r.red = red; r.rpc = rpc; r.hlt = hlt; r.ir = ir;
    r.rm = rm; r.a = a; r.vl = vl; r.pc = pc; r.fc = fc; r.h = h;
    return r;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic do_reset();
    Reset = 1'b1;
    i_ready = 0; redirect = 0; redirect_pc = 0; halt = 0; inst_ready = 0;
    @(negedge Clk);
    Reset = 1'b0;
  endtask
  task automatic check_out(string tag, bit rm, logic [15:0] a, bit vl, logic [15:0] pc, logic [15:0] fc, bit h);
    chk({tag, ".i_readM"}, 32'(i_readM), 32'(rm));
    chk({tag, ".i_address"}, 32'(i_address), 32'(a));
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(vl));
    chk({tag, ".inst_pc"}, 32'(inst_pc), 32'(vl ? pc : 16'h0));
    chk({tag, ".inst"}, 32'(inst), 32'(vl ? (16'h5A00 ^ pc) : 16'h0));
    chk({tag, ".fetch_count"}, 32'(fetch_count), 32'(fc));
    chk({tag, ".is_halted"}, 32'(is_halted), 32'(h));
  endtask
  task automatic cyc(string tag, bit rdy, bit red, logic [15:0] rpc, bit hlt, bit ir,
                     bit rm, logic [15:0] a, bit vl, logic [15:0] pc, logic [15:0] fc, bit h);
    i_ready = rdy; redirect = red; redirect_pc = rpc; halt = hlt; inst_ready = ir;
    #1;
    check_out(tag, rm, a, vl, pc, fc, h);
    @(negedge Clk);
  endtask
  initial begin
    Reset = 1'b1;
    i_ready = 0; redirect = 0; redirect_pc = 0; halt = 0; inst_ready = 0;
    @(negedge Clk);
    #1;
    check_out("reset", 0, 16'h0, 0, 16'h0, 16'h0, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("reset.flush_count", 32'(flush_count), 32'h0);
`endif
    @(negedge Clk);
    // zero-wait memory, decode always ready: one instruction per cycle
    vq.push_back(v(1, 1, 0, 0, 0, 1, 1, 16'd0, 0, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 1, 16'd0, 0, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 1, 16'd1, 1, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 1, 16'd2, 1, 16'd1, 16'd1, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 1, 16'd3, 1, 16'd2, 16'd2, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 1, 1, 16'd4, 1, 16'd3, 16'd3, 0));
    // 3-cycle memory, decode stalled: fills to DEPTH, then one pop frees one fetch
    vq.push_back(v(1, 0, 0, 0, 0, 0, 1, 16'd0, 0, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 16'd0, 0, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 16'd0, 0, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 0, 1, 16'd0, 0, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 16'd1, 1, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 16'd1, 1, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 0, 1, 16'd1, 1, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 16'd2, 1, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 16'd2, 1, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 0, 1, 16'd2, 1, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 16'd3, 1, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 16'd3, 1, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 0, 1, 16'd3, 1, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 16'd4, 1, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 0, 16'd4, 1, 16'd0, 16'd0, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 16'd4, 1, 16'd1, 16'd1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 16'd4, 1, 16'd1, 16'd1, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 0, 1, 16'd4, 1, 16'd1, 16'd1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 16'd5, 1, 16'd1, 16'd1, 0));
    foreach (vq[i]) begin
      if (vq[i].rs) do_reset();
      cyc($sformatf("vec%0d", i), vq[i].rdy, vq[i].red, vq[i].rpc, vq[i].hlt, vq[i].ir,
          vq[i].rm, vq[i].a, vq[i].vl, vq[i].pc, vq[i].fc, vq[i].h);
    end
    // redirect while a response is two cycles away
    do_reset();
    cyc("redir0", 0, 0, 0, 0, 0, 1, 16'h0, 0, 16'h0, 16'h0, 0);
    cyc("redir1", 1, 0, 0, 0, 0, 1, 16'h0, 0, 16'h0, 16'h0, 0);
    cyc("redir2", 0, 0, 0, 0, 0, 1, 16'h1, 1, 16'h0, 16'h0, 0);
    cyc("redir3", 0, 1, 16'h40, 0, 0, 1, 16'h1, 1, 16'h0, 16'h0, 0);
    cyc("redir4", 0, 0, 0, 0, 0, 1, 16'h1, 0, 16'h0, 16'h0, 0);
    cyc("redir5", 1, 0, 0, 0, 0, 1, 16'h1, 0, 16'h0, 16'h0, 0);
    cyc("redir6", 0, 0, 0, 0, 0, 1, 16'h40, 0, 16'h0, 16'h0, 0);
    cyc("redir7", 1, 0, 0, 0, 0, 1, 16'h40, 0, 16'h0, 16'h0, 0);
    cyc("redir8", 0, 0, 0, 0, 0, 1, 16'h41, 1, 16'h40, 16'h0, 0);
    // redirect coinciding with a response and a pop
    do_reset();
    cyc("rpop0", 1, 0, 0, 0, 0, 1, 16'h0, 0, 16'h0, 16'h0, 0);
    cyc("rpop1", 1, 0, 0, 0, 0, 1, 16'h0, 0, 16'h0, 16'h0, 0);
    cyc("rpop2", 1, 1, 16'h80, 0, 1, 1, 16'h1, 1, 16'h0, 16'h0, 0);
    cyc("rpop3", 0, 0, 0, 0, 1, 1, 16'h80, 0, 16'h0, 16'h0, 0);
    cyc("rpop4", 1, 0, 0, 0, 1, 1, 16'h80, 0, 16'h0, 16'h0, 0);
    cyc("rpop5", 0, 0, 0, 0, 1, 1, 16'h81, 1, 16'h80, 16'h0, 0);
    cyc("rpop6", 0, 0, 0, 0, 1, 1, 16'h81, 0, 16'h0, 16'h1, 0);
    // halt pulse during an outstanding request
    do_reset();
    cyc("halt0", 0, 0, 0, 0, 0, 1, 16'h0, 0, 16'h0, 16'h0, 0);
    cyc("halt1", 0, 0, 0, 1, 0, 1, 16'h0, 0, 16'h0, 16'h0, 0);
    cyc("halt2", 0, 0, 0, 0, 0, 1, 16'h0, 0, 16'h0, 16'h0, 0);
    cyc("halt3", 1, 0, 0, 0, 0, 1, 16'h0, 0, 16'h0, 16'h0, 0);
    cyc("halt4", 0, 0, 0, 0, 1, 0, 16'h1, 1, 16'h0, 16'h0, 1);
    cyc("halt5", 0, 0, 0, 0, 1, 0, 16'h1, 0, 16'h0, 16'h1, 1);
    cyc("halt6", 0, 1, 16'h20, 0, 0, 0, 16'h1, 0, 16'h0, 16'h1, 1);
    cyc("halt7", 0, 0, 0, 0, 0, 0, 16'h1, 0, 16'h0, 16'h1, 1);
`ifdef FETCH_PERF_CNT_EN
    // three queued entries flushed plus one dropped response
    do_reset();
    cyc("perf0", 1, 0, 0, 0, 0, 1, 16'h0, 0, 16'h0, 16'h0, 0);
    cyc("perf1", 1, 0, 0, 0, 0, 1, 16'h0, 0, 16'h0, 16'h0, 0);
    cyc("perf2", 1, 0, 0, 0, 0, 1, 16'h1, 1, 16'h0, 16'h0, 0);
    cyc("perf3", 1, 0, 0, 0, 0, 1, 16'h2, 1, 16'h0, 16'h0, 0);
    cyc("perf4", 0, 1, 16'h10, 0, 0, 1, 16'h3, 1, 16'h0, 16'h0, 0);
    chk("perf.flush_count_after_flush", 32'(flush_count), 32'd3);
    cyc("perf5", 1, 0, 0, 0, 0, 1, 16'h3, 0, 16'h0, 16'h0, 0);
    cyc("perf6", 0, 0, 0, 0, 0, 1, 16'h10, 0, 16'h0, 16'h0, 0);
    chk("perf.flush_count_after_drop", 32'(flush_count), 32'd4);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
